// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, default width, output-stage states.
package alu_arbiter_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SRL  = 3'd4;
  localparam logic [2:0] ALU_SRA  = 3'd5;
  localparam logic [2:0] ALU_SGTU = 3'd6;
  localparam logic [2:0] ALU_SGT  = 3'd7;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational shared ALU: C = op(A, B). WIDTH is assumed to be a power of two.
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] c_o
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [ShW-1:0] shamt;
  logic           sh_big;

  assign shamt  = b_i[ShW-1:0];
  // Shift amounts use the full B operand; anything >= WIDTH saturates.
  assign sh_big = (b_i >= WIDTH'(WIDTH));

  always_comb begin
    c_o = '0;
    case (op_i)
      ALU_ADD:  c_o = a_i + b_i;
      ALU_SUB:  c_o = a_i - b_i;
      ALU_AND:  c_o = a_i & b_i;
      ALU_OR:   c_o = a_i | b_i;
      ALU_SRL:  c_o = sh_big ? '0 : (a_i >> shamt);
      ALU_SRA:  c_o = sh_big ? {WIDTH{a_i[WIDTH-1]}} : WIDTH'($signed(a_i) >>> shamt);
      ALU_SGTU: c_o = WIDTH'(a_i > b_i);
      ALU_SGT:  c_o = WIDTH'($signed(a_i) > $signed(b_i));
      default:  c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU with a single-entry registered result stage.
// Tie-break: round-robin when ALU_ARB_ROUND_ROBIN_EN is defined, otherwise requester 0 wins.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_id
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
  logic             rsp_id_q, rsp_id_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic [2:0]       alu_op;

  assign can_accept  = (state_q == StEmpty) | rsp_ready;
  assign grant_valid = req0_valid | req1_valid;

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      grant_id = ~last_grant_q;
`else
      grant_id = 1'b0;
`endif
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

`ifndef ALU_ARB_ROUND_ROBIN_EN
  // Fixed priority still tracks the last grant but never consults it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  assign accept     = can_accept & grant_valid & ~reset;
  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept & grant_id;

  assign alu_a  = grant_id ? req1_a  : req0_a;
  assign alu_b  = grant_id ? req1_b  : req0_b;
  assign alu_op = grant_id ? req1_op : req0_op;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a_i  (alu_a),
    .b_i  (alu_b),
    .op_i (alu_op),
    .c_o  (alu_c)
  );

  always_comb begin
    state_d      = state_q;
    rsp_c_d      = rsp_c_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      state_d      = StFull;
      rsp_c_d      = alu_c;
      rsp_id_d     = grant_id;
      last_grant_d = grant_id;
    end else if ((state_q == StFull) && rsp_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StEmpty;
      rsp_c_q      <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_c_q      <= rsp_c_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_c     = rsp_c_q;
  assign rsp_id    = rsp_id_q;

endmodule
